adc_sample_conditioner: RTL and testbench

- Upstream front end for the MOSFET pulse controller. Takes raw dual-channel ADC samples for gap current and gap voltage and produces signed, offset-calibrated, averaged and scaled values on the controller's sample_current and sample_voltage inputs.
- Runs a zero-offset calibration after reset and on request.
- Keeps a moving average per channel and flags ADC over-range.

---
 rtl/adc_sample_conditioner.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_adc_sample_conditioner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: converts offset-binary gap current/voltage codes to signed values,
// removes a calibrated zero offset, applies a moving average and a per-channel gain shift
// with 17-bit saturation. Calibration runs after reset and on cal_start.
// Optional build macro: ADC_MEDIAN3_FILTER_EN inserts a 3-tap median after stage 1.
module adc_sample_conditioner #(
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned CAL_LOG2       = 8,
  parameter int unsigned CUR_GAIN_SHIFT = 2,
  parameter int unsigned VOL_GAIN_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_cur_raw,
  input  logic [11:0] adc_vol_raw,
  input  logic        adc_data_valid,
  input  logic        cal_start,
  input  logic        overrange_clr,
  output logic [16:0] sample_current,
  output logic [16:0] sample_voltage,
  output logic        sample_valid,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        adc_overrange
);

  localparam int unsigned Depth   = 1 << AVG_LOG2;
  localparam int unsigned SumW    = 14 + AVG_LOG2;
  localparam int unsigned PtrW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned FillW   = AVG_LOG2 + 1;
  localparam int unsigned CalCntW = CAL_LOG2 + 1;
  localparam logic [CalCntW-1:0] CalLast  = CalCntW'((1 << CAL_LOG2) - 1);
  localparam logic [FillW-1:0]   FillFull = FillW'(Depth);
  localparam logic [PtrW-1:0]    PtrLast  = PtrW'(Depth - 1);

  localparam logic [1:0] S_RST = 2'd0;
  localparam logic [1:0] S_CAL = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;

  logic [1:0]               r_state;
  logic                     r_ovr;
  logic                     r_s_valid;
  logic signed [12:0]       r_cur_s, r_vol_s;
  logic                     w_fe_valid;
  logic signed [12:0]       w_fe_cur, w_fe_vol;
  logic signed [23:0]       r_cur_acc, r_vol_acc;
  logic signed [23:0]       w_cur_acc_nxt, w_vol_acc_nxt;
  logic [CalCntW-1:0]       r_cal_cnt;
  logic signed [12:0]       r_cur_off, r_vol_off;
  logic                     r_cal_done;
  logic                     w_run_in, w_clr_avg, w_full, w_ovr_hit;
  logic                     r_d_valid;
  logic signed [13:0]       r_cur_d, r_vol_d;
  logic signed [13:0]       r_cur_buf [Depth];
  logic signed [13:0]       r_vol_buf [Depth];
  logic signed [13:0]       w_cur_old, w_vol_old;
  logic signed [SumW-1:0]   r_cur_sum, r_vol_sum;
  logic [PtrW-1:0]          r_ptr;
  logic [FillW-1:0]         r_fill;
  logic                     r_sum_valid;
  logic                     r_out_valid;
  logic [16:0]              r_out_cur, r_out_vol;

  assign sample_current = r_out_cur;
  assign sample_voltage = r_out_vol;
  assign sample_valid   = r_out_valid;
  assign cal_busy       = (r_state == S_CAL);
  assign cal_done       = r_cal_done;
  assign adc_overrange  = r_ovr;

  assign w_ovr_hit = adc_data_valid &&
                     (adc_cur_raw == 12'd0 || adc_cur_raw == 12'hFFF ||
                      adc_vol_raw == 12'd0 || adc_vol_raw == 12'hFFF);

  // Sticky over-range flag; a new hit outranks a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovr <= 1'b0;
    else if (w_ovr_hit) r_ovr <= 1'b1;
    else if (overrange_clr) r_ovr <= 1'b0;
  end

  // Stage 1: offset-binary to signed, captured on each valid strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_cur_s   <= '0;
      r_vol_s   <= '0;
    end else begin
      r_s_valid <= adc_data_valid;
      if (adc_data_valid) begin
        r_cur_s <= $signed({1'b0, adc_cur_raw}) - 13'sd2048;
        r_vol_s <= $signed({1'b0, adc_vol_raw}) - 13'sd2048;
      end
    end
  end

`ifdef ADC_MEDIAN3_FILTER_EN
  logic                 w_cal_enter;
  logic                 r_m_valid;
  logic [1:0]           r_med_cnt;
  logic signed [12:0]   r_cur_h1, r_cur_h2, r_vol_h1, r_vol_h2, r_cur_m, r_vol_m;

  // History restarts whenever a calibration begins
  assign w_cal_enter = (r_state == S_RST) || cal_start;

  function automatic logic signed [12:0] med3(input logic signed [12:0] a,
                                              input logic signed [12:0] b,
                                              input logic signed [12:0] c);
    logic signed [12:0] lo, hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    med3 = (c < lo) ? lo : ((c > hi) ? hi : c);
  endfunction

  // Median of the newest three stage-1 values; the first two after a clear pass through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_med_cnt <= 2'd0;
      r_cur_h1  <= '0;
      r_cur_h2  <= '0;
      r_vol_h1  <= '0;
      r_vol_h2  <= '0;
      r_cur_m   <= '0;
      r_vol_m   <= '0;
    end else begin
      r_m_valid <= r_s_valid && !w_cal_enter;
      if (w_cal_enter) begin
        r_med_cnt <= 2'd0;
        r_cur_h1  <= '0;
        r_cur_h2  <= '0;
        r_vol_h1  <= '0;
        r_vol_h2  <= '0;
      end else if (r_s_valid) begin
        r_cur_m  <= (r_med_cnt == 2'd2) ? med3(r_cur_s, r_cur_h1, r_cur_h2) : r_cur_s;
        r_vol_m  <= (r_med_cnt == 2'd2) ? med3(r_vol_s, r_vol_h1, r_vol_h2) : r_vol_s;
        r_cur_h1 <= r_cur_s;
        r_cur_h2 <= r_cur_h1;
        r_vol_h1 <= r_vol_s;
        r_vol_h2 <= r_vol_h1;
        if (r_med_cnt != 2'd2) r_med_cnt <= r_med_cnt + 2'd1;
      end
    end
  end

  assign w_fe_valid = r_m_valid;
  assign w_fe_cur   = r_cur_m;
  assign w_fe_vol   = r_vol_m;
`else
  assign w_fe_valid = r_s_valid;
  assign w_fe_cur   = r_cur_s;
  assign w_fe_vol   = r_vol_s;
`endif

  assign w_cur_acc_nxt = r_cur_acc + 24'(w_fe_cur);
  assign w_vol_acc_nxt = r_vol_acc + 24'(w_fe_vol);

  // Control FSM and offset calibration; cal_start always restarts from count 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RST;
      r_cur_acc  <= '0;
      r_vol_acc  <= '0;
      r_cal_cnt  <= '0;
      r_cur_off  <= '0;
      r_vol_off  <= '0;
      r_cal_done <= 1'b0;
    end else begin
      r_cal_done <= 1'b0;
      case (r_state)
        S_RST: r_state <= S_CAL;
        S_CAL: begin
          if (cal_start) begin
            r_cur_acc <= '0;
            r_vol_acc <= '0;
            r_cal_cnt <= '0;
          end else if (w_fe_valid) begin
            if (r_cal_cnt == CalLast) begin
              r_cur_off  <= 13'(w_cur_acc_nxt >>> CAL_LOG2);
              r_vol_off  <= 13'(w_vol_acc_nxt >>> CAL_LOG2);
              r_cur_acc  <= '0;
              r_vol_acc  <= '0;
              r_cal_cnt  <= '0;
              r_cal_done <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_cur_acc <= w_cur_acc_nxt;
              r_vol_acc <= w_vol_acc_nxt;
              r_cal_cnt <= r_cal_cnt + CalCntW'(1);
            end
          end
        end
        S_RUN: begin
          if (cal_start) begin
            r_state   <= S_CAL;
            r_cur_acc <= '0;
            r_vol_acc <= '0;
            r_cal_cnt <= '0;
          end
        end
        default: r_state <= S_RST;
      endcase
    end
  end

  assign w_run_in  = w_fe_valid && (r_state == S_RUN) && !cal_start;
  assign w_clr_avg = (r_state == S_RUN) && cal_start;

  // Stage 2: offset removal, only while running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_cur_d   <= '0;
      r_vol_d   <= '0;
    end else begin
      r_d_valid <= w_run_in;
      if (w_run_in) begin
        r_cur_d <= 14'(w_fe_cur) - 14'(r_cur_off);
        r_vol_d <= 14'(w_fe_vol) - 14'(r_vol_off);
      end
    end
  end

  // Until the ring is full the evicted entry counts as zero, so the average ramps up
  assign w_full    = (r_fill == FillFull);
  assign w_cur_old = w_full ? r_cur_buf[r_ptr] : '0;
  assign w_vol_old = w_full ? r_vol_buf[r_ptr] : '0;

  // Stage 3: running-sum moving average over a ring buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        r_cur_buf[i] <= '0;
        r_vol_buf[i] <= '0;
      end
      r_cur_sum   <= '0;
      r_vol_sum   <= '0;
      r_ptr       <= '0;
      r_fill      <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= r_d_valid && !w_clr_avg;
      if (w_clr_avg) begin
        r_cur_sum <= '0;
        r_vol_sum <= '0;
        r_ptr     <= '0;
        r_fill    <= '0;
      end else if (r_d_valid) begin
        r_cur_sum        <= r_cur_sum + SumW'(r_cur_d) - SumW'(w_cur_old);
        r_vol_sum        <= r_vol_sum + SumW'(r_vol_d) - SumW'(w_vol_old);
        r_cur_buf[r_ptr] <= r_cur_d;
        r_vol_buf[r_ptr] <= r_vol_d;
        r_ptr            <= (r_ptr == PtrLast) ? '0 : r_ptr + PtrW'(1);
        if (!w_full) r_fill <= r_fill + FillW'(1);
      end
    end
  end

  function automatic logic [16:0] scale_sat(input logic signed [SumW-1:0] sum,
                                            input int unsigned shift);
    logic signed [31:0] avg, scaled;
    avg    = 32'(sum) >>> AVG_LOG2;
    scaled = avg <<< shift;
    if (scaled > 32'sd65535) scale_sat = 17'h0FFFF;
    else if (scaled < -32'sd65536) scale_sat = 17'h10000;
    else scale_sat = scaled[16:0];
  endfunction

  // Stage 4: divide, apply gain, saturate; outputs hold between valid strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_cur   <= '0;
      r_out_vol   <= '0;
    end else begin
      r_out_valid <= r_sum_valid && !w_clr_avg;
      if (r_sum_valid && !w_clr_avg) begin
        r_out_cur <= scale_sat(r_cur_sum, CUR_GAIN_SHIFT);
        r_out_vol <= scale_sat(r_vol_sum, VOL_GAIN_SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Directed bench for adc_sample_conditioner: calibration, latency/ramp, saturation,
// over-range, recalibration and mid-stream reset. A second instance uses a large
// current gain for the saturation cases.
module tb_adc_sample_conditioner;

`ifdef ADC_MEDIAN3_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_cur_raw = 12'd2048;
  logic [11:0] adc_vol_raw = 12'd2048;
  logic        adc_data_valid = 1'b0;
  logic        cal_start = 1'b0;
  logic        overrange_clr = 1'b0;
  logic [16:0] sample_current, sample_voltage, s_cur, s_vol;
  logic        sample_valid, cal_busy, cal_done, adc_overrange;
  logic        s_sv, s_busy, s_done, s_ovr;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_sv = 0;
  int cyc = 0;
  int sv_before;
  int q_cur[$];
  int q_vol[$];
  int q_cyc[$];
  int s_cyc[$];
  int ramp_exp [5] = '{100, 200, 300, 400, 400};

  adc_sample_conditioner u_dut (
    .clk           (clk),
    .rst           (rst),
    .adc_cur_raw   (adc_cur_raw),
    .adc_vol_raw   (adc_vol_raw),
    .adc_data_valid(adc_data_valid),
    .cal_start     (cal_start),
    .overrange_clr (overrange_clr),
    .sample_current(sample_current),
    .sample_voltage(sample_voltage),
    .sample_valid  (sample_valid),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .adc_overrange (adc_overrange)
  );

  adc_sample_conditioner #(.CUR_GAIN_SHIFT(6)) u_sat (
    .clk           (clk),
    .rst           (rst),
    .adc_cur_raw   (adc_cur_raw),
    .adc_vol_raw   (adc_vol_raw),
    .adc_data_valid(adc_data_valid),
    .cal_start     (cal_start),
    .overrange_clr (overrange_clr),
    .sample_current(s_cur),
    .sample_voltage(s_vol),
    .sample_valid  (s_sv),
    .cal_busy      (s_busy),
    .cal_done      (s_done),
    .adc_overrange (s_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cal_done) n_done++;
    if (sample_valid) begin
      n_sv++;
      q_cur.push_back($signed(sample_current));
      q_vol.push_back($signed(sample_voltage));
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] c, input logic [11:0] v);
    adc_cur_raw    = c;
    adc_vol_raw    = v;
    adc_data_valid = 1'b1;
    s_cyc.push_back(cyc);
    tick();
    adc_data_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_q();
    q_cur.delete();
    q_vol.delete();
    q_cyc.delete();
    s_cyc.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_cur", $signed(sample_current), 0);
    chk("rst_vol", $signed(sample_voltage), 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_ovr", adc_overrange, 0);
    rst = 1'b0;
    tick();
    chk("busy_after_rst", cal_busy, 1);

    // Initial calibration: cur offset 10, vol offset -8
    for (int i = 0; i < 256; i++) begin
      send(12'd2058, 12'd2040);
      if (i == 128) chk("cal_busy_mid", cal_busy, 1);
    end
    repeat (LAT - 4) tick();
    chk("cal_busy_last", cal_busy, 1);
    chk("cal_no_early_done", n_done, 0);
    tick();
    chk("cal_done_pulse", cal_done, 1);
    chk("cal_busy_clear", cal_busy, 0);
    tick();
    chk("cal_done_once", n_done, 1);
    chk("cal_no_valid", n_sv, 0);

    // First run sample with the calibration codes: exact latency, zero output
    send(12'd2058, 12'd2040);
    repeat (LAT - 2) tick();
    chk("lat_not_early", sample_valid, 0);
    tick();
    chk("lat_valid", sample_valid, 1);
    chk("cal_zero_cur", $signed(sample_current), 0);
    chk("cal_zero_vol", $signed(sample_voltage), 0);
    tick();
    chk("valid_one_cycle", sample_valid, 0);

    // Recalibration mid-stream with three samples in flight
    sv_before = n_sv;
    repeat (3) send(12'd2058, 12'd2040);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("recal_busy", cal_busy, 1);
    for (int i = 0; i < 100; i++) send(12'd2048, 12'd2048);
    repeat (2) tick();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int i = 0; i < 255; i++) send(12'd2048, 12'd2048);
    repeat (2) tick();
    chk("recal_restart_no_done", n_done, 1);
    chk("recal_restart_busy", cal_busy, 1);
    send(12'd2048, 12'd2048);
    repeat (LAT - 4) tick();
    tick();
    chk("recal_done_pulse", cal_done, 1);
    tick();
    chk("recal_done_count", n_done, 2);
    chk("recal_no_valid", n_sv, sv_before);

    // Averaging ramp with zero offsets
    clear_q();
    repeat (5) send(12'd2148, 12'd2048);
    repeat (LAT + 1) tick();
    chk("ramp_count", q_cur.size(), 5);
    if (q_cur.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("ramp_cur%0d", i), q_cur[i], ramp_exp[i]);
        chk($sformatf("ramp_vol%0d", i), q_vol[i], 0);
        chk($sformatf("ramp_lat%0d", i), q_cyc[i] - s_cyc[i], LAT);
      end
    end

    // Over-range: sticky, set beats clear, lone clear works
    chk("ovr_idle", adc_overrange, 0);
    send(12'd2048, 12'd4095);
    chk("ovr_set", adc_overrange, 1);
    repeat (3) send(12'd2048, 12'd2048);
    chk("ovr_sticky", adc_overrange, 1);
    adc_cur_raw    = 12'd0;
    adc_data_valid = 1'b1;
    overrange_clr  = 1'b1;
    tick();
    adc_data_valid = 1'b0;
    chk("ovr_set_wins", adc_overrange, 1);
    tick();
    overrange_clr = 1'b0;
    chk("ovr_cleared", adc_overrange, 0);

    // Saturation on the high-gain instance
    repeat (8) send(12'd4094, 12'd2048);
    repeat (LAT + 1) tick();
    chk("sat_hi", $signed(s_cur), 65535);
    chk("nosat_hi", $signed(sample_current), 8184);
    chk("sat_vol", $signed(s_vol), 0);
    repeat (8) send(12'd1, 12'd2048);
    repeat (LAT + 1) tick();
    chk("sat_lo", $signed(s_cur), -65536);
    chk("nosat_lo", $signed(sample_current), -8188);
    chk("sat_busy", s_busy, 0);
    chk("sat_done", s_done, 0);
    chk("sat_sv_idle", s_sv, 0);
    chk("sat_ovr", s_ovr, 0);

`ifdef ADC_MEDIAN3_FILTER_EN
    // A single spike is removed by the median
    repeat (8) send(12'd2048, 12'd2048);
    repeat (LAT + 1) tick();
    clear_q();
    send(12'd4000, 12'd4000);
    repeat (4) send(12'd2048, 12'd2048);
    repeat (LAT + 1) tick();
    chk("med_count", q_cur.size(), 5);
    if (q_cur.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("med_cur%0d", i), q_cur[i], 0);
        chk($sformatf("med_vol%0d", i), q_vol[i], 0);
        chk($sformatf("med_lat%0d", i), q_cyc[i] - s_cyc[i], 5);
      end
    end
`endif

    // Mid-stream reset with three samples in flight
    sv_before = n_sv;
    repeat (3) send(12'd2148, 12'd2148);
    rst = 1'b1;
    repeat (2) tick();
    chk("mrst_cur", $signed(sample_current), 0);
    chk("mrst_vol", $signed(sample_voltage), 0);
    chk("mrst_busy", cal_busy, 0);
    chk("mrst_ovr", adc_overrange, 0);
    rst = 1'b0;
    tick();
    chk("mrst_busy_rise", cal_busy, 1);
    repeat (6) tick();
    chk("mrst_no_valid", n_sv, sv_before);
    chk("mrst_cur_hold", $signed(sample_current), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
